// File: rtl/conv_win_sched_if.sv
// conv_win_sched_if: controller/downstream handshake and window/result tags
// for the conv window scheduler. Widths are the tag widths of the top.
interface conv_win_sched_if #(
  parameter int unsigned KW = 3,
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 5
);
  logic          start;
  logic          abort;
  logic          ds_ready;
  logic          busy;
  logic          done;
  logic          win_valid;
  logic [KW-1:0] win_ker;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          res_valid;
  logic [KW-1:0] res_ker;
  logic [RW-1:0] res_row;
  logic [CW-1:0] res_col;
  logic [15:0]   perf_stall;

  // Layer controller / bench side
  modport master (
    output start, abort, ds_ready,
    input  busy, done, win_valid, win_ker, win_row, win_col,
    input  res_valid, res_ker, res_row, res_col, perf_stall
  );

  // Scheduler side
  modport slave (
    input  start, abort, ds_ready,
    output busy, done, win_valid, win_ker, win_row, win_col,
    output res_valid, res_ker, res_row, res_col, perf_stall
  );
endinterface

// File: rtl/conv_win_sched.sv
// conv_win_sched: walks kernel -> output row -> output column, issuing one
// window request per SLOT clocks, and tags results LAT clocks later.
// Optional stall counter on perf_stall: define CONV_WIN_SCHED_PERF_EN.
module conv_win_sched #(
  parameter int unsigned IMG_W   = 32,
  parameter int unsigned IMG_H   = 32,
  parameter int unsigned K       = 5,
  parameter int unsigned NUM_KER = 6,
  parameter int unsigned SLOT    = 8,
  parameter int unsigned LAT     = 9
) (
  input  logic            clk,
  input  logic            rstn,
  conv_win_sched_if.slave bus
);

  localparam int unsigned OUT_W = IMG_W - K + 1;
  localparam int unsigned OUT_H = IMG_H - K + 1;
  localparam int unsigned KW    = (NUM_KER > 1) ? $clog2(NUM_KER) : 1;
  localparam int unsigned RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned SW    = (SLOT > 2) ? $clog2(SLOT - 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE
  } state_e;

  typedef struct packed {
    logic [KW-1:0] ker;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } tag_t;

  state_e        state_q, state_d;
  logic [KW-1:0] ker_q, ker_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [LAT-1:0] dl_v_q, dl_v_d;
  tag_t          dl_tag_q [LAT];
  tag_t          dl_tag_d [LAT];

  logic win_valid_c;
  logic last_win_c;
  logic pending_c;
  logic kill_c;

  // Issue strobe is a pure decode so a stalled slot costs no extra cycle
  assign win_valid_c = (state_q == S_ISSUE) && bus.ds_ready;
  assign last_win_c  = (ker_q == KW'(NUM_KER - 1)) && (row_q == RW'(OUT_H - 1)) &&
                       (col_q == CW'(OUT_W - 1));
  assign kill_c      = (state_q != S_IDLE) && bus.abort;

  // Next-state, index walk and delay-line shift
  always_comb begin
    state_d = state_q;
    ker_d   = ker_q;
    row_d   = row_q;
    col_d   = col_q;
    slot_d  = slot_q;

    // Results still in flight, excluding the one presented this cycle
    pending_c = 1'b0;
    for (int unsigned i = 0; i + 1 < LAT; i++) pending_c = pending_c | dl_v_q[i];

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = S_ISSUE;
          ker_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_ISSUE: begin
        if (bus.ds_ready) begin
          state_d = S_WAIT;
          slot_d  = SW'(SLOT - 2);
        end
      end
      S_WAIT: begin
        if (slot_q == '0) begin
          if (last_win_c) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ISSUE;
            if (col_q == CW'(OUT_W - 1)) begin
              col_d = '0;
              if (row_q == RW'(OUT_H - 1)) begin
                row_d = '0;
                ker_d = ker_q + 1'b1;
              end else begin
                row_d = row_q + 1'b1;
              end
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end else begin
          slot_d = slot_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (!pending_c) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (kill_c) state_d = S_IDLE;

    dl_v_d[0]   = win_valid_c;
    dl_tag_d[0] = '{ker: ker_q, row: row_q, col: col_q};
    for (int unsigned i = 1; i < LAT; i++) begin
      dl_v_d[i]   = dl_v_q[i-1];
      dl_tag_d[i] = dl_tag_q[i-1];
    end
    if (kill_c) dl_v_d = '0;

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, indices, status and delay line
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ker_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      slot_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dl_v_q  <= '0;
      for (int unsigned i = 0; i < LAT; i++) dl_tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ker_q   <= ker_d;
      row_q   <= row_d;
      col_q   <= col_d;
      slot_q  <= slot_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dl_v_q  <= dl_v_d;
      for (int unsigned i = 0; i < LAT; i++) dl_tag_q[i] <= dl_tag_d[i];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.win_valid = win_valid_c;
  assign bus.win_ker   = ker_q;
  assign bus.win_row   = row_q;
  assign bus.win_col   = col_q;
  assign bus.res_valid = dl_v_q[LAT-1];
  assign bus.res_ker   = dl_tag_q[LAT-1].ker;
  assign bus.res_row   = dl_tag_q[LAT-1].row;
  assign bus.res_col   = dl_tag_q[LAT-1].col;

`ifdef CONV_WIN_SCHED_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Saturating count of stalled issue cycles, cleared by an accepted start
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && bus.start && !bus.abort) begin
      perf_d = '0;
    end else if ((state_q == S_ISSUE) && !bus.ds_ready && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!rstn) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign bus.perf_stall = perf_q;
`else
  assign bus.perf_stall = 16'd0;
`endif

endmodule

// File: tb/tb_conv_win_sched.sv
// tb_conv_win_sched: scoreboard bench for conv_win_sched. A small-geometry
// instance is driven with directed and random traffic against a timing model;
// a default-geometry instance checks the full 4704-window walk.
module tb_conv_win_sched;
  localparam int unsigned IMG_W = 8, IMG_H = 6, K = 5, NUM_KER = 2, SLOT = 8, LAT = 9;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam int TOTAL = NUM_KER * OUT_H * OUT_W;
  localparam int B_OUT = 28;
  localparam int B_TOTAL = 6 * B_OUT * B_OUT;

  logic clk = 1'b0;
  logic rstn, big_rstn;
  always #5 clk = ~clk;

  conv_win_sched_if #(.KW(1), .RW(1), .CW(2)) bus ();
  conv_win_sched_if #(.KW(3), .RW(5), .CW(5)) big_bus ();

  conv_win_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .NUM_KER(NUM_KER),
                   .SLOT(SLOT), .LAT(LAT))
    u_dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

  conv_win_sched #(.IMG_W(32), .IMG_H(32), .K(5), .NUM_KER(6), .SLOT(2), .LAT(3))
    u_big (.clk(clk), .rstn(big_rstn), .bus(big_bus.slave));

  typedef struct { int cyc; int k; int r; int c; } ev_t;
  typedef struct { int cyc; bit busy; int perf; } st_t;

  ev_t win_q[$];
  ev_t res_q[$];
  int  done_q[$];
  st_t st_q[$];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // Reference model state (frame-level, in cycles)
  bit m_active = 1'b0;
  bit m_last   = 1'b0;
  int m_n, m_next, m_done;
  int m_perf = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endfunction

  function automatic void drop_after(input int c);
    while (res_q.size() != 0 && res_q[$].cyc > c) void'(res_q.pop_back());
    while (done_q.size() != 0 && done_q[$] > c) void'(done_q.pop_back());
  endfunction

  // Predict this cycle's outputs and schedule future results from the inputs
  task automatic model_cycle(input bit st, input bit ab, input bit rdy, input bit rn);
    int c;
    c = cyc;
    if (m_active && m_last && c > m_done) m_active = 1'b0;
    if (chk_en) st_q.push_back('{c, m_active, m_perf});
    if (m_active && !m_last && c >= m_next) begin
      if (rdy) begin
        ev_t e;
        e = '{c, m_n / (OUT_H * OUT_W), (m_n / OUT_W) % OUT_H, m_n % OUT_W};
        win_q.push_back(e);
        e.cyc = c + LAT;
        res_q.push_back(e);
        m_n++;
        m_next = c + SLOT;
        if (m_n == TOTAL) begin
          m_last = 1'b1;
          m_done = ((SLOT > LAT) ? c + SLOT : c + LAT) + 1;
          done_q.push_back(m_done);
        end
      end else if (m_perf < 65535) begin
        m_perf++;
      end
    end
    if (!rn) begin
      drop_after(c);
      m_active = 1'b0;
      m_perf   = 0;
    end else if (m_active && ab) begin
      drop_after(c);
      m_active = 1'b0;
    end else if (!m_active && st && !ab) begin
      m_active = 1'b1;
      m_last   = 1'b0;
      m_n      = 0;
      m_next   = c + 1;
      m_perf   = 0;
    end
  endtask

  task automatic step(input bit st, input bit ab, input bit rdy, input bit rn);
    @(posedge clk);
    #1;
    bus.start    = st;
    bus.abort    = ab;
    bus.ds_ready = rdy;
    rstn         = rn;
    model_cycle(st, ab, rdy, rn);
  endtask

  // One scenario of len cycles; start is pulsed at relative cycle 0 unless kind is 0
  task automatic scenario(input int len, input int kind);
    for (int r = 0; r < len; r++) begin
      bit st, ab, rdy, rn;
      st = (r == 0) && (kind != 0);
      ab = 1'b0; rdy = 1'b1; rn = 1'b1;
      case (kind)
        2: rdy = !(r >= 9 && r <= 13);
        3: begin
          ab = (r == 40);
          st = st || (r == 45);
          if (r == 200) begin st = 1'b1; ab = 1'b1; end
        end
        4: st = st || (r == 20) || (r == 60);
        6: begin rn = (r != 50); st = st || (r == 55); end
        7: begin
          rdy = ($urandom_range(0, 3) != 0);
          st  = st || ($urandom_range(0, 49) == 0);
          ab  = ($urandom_range(0, 399) == 0);
        end
        default: ;
      endcase
      step(st, ab, rdy, rn);
    end
  endtask

  // Scoreboard monitor: pops expectations as the DUT presents outputs
  always @(negedge clk) begin
    if (chk_en) begin
      bit ew, er, ed;
      ev_t e;
      st_t s;
      if (st_q.size() != 0 && st_q[0].cyc == cyc) begin
        s = st_q.pop_front();
        chk("busy", bus.busy, s.busy);
`ifdef CONV_WIN_SCHED_PERF_EN
        chk("perf_stall", bus.perf_stall, s.perf);
`else
        chk("perf_stall", bus.perf_stall, 0);
`endif
      end
      ew = (win_q.size() != 0) && (win_q[0].cyc == cyc);
      chk("win_valid", bus.win_valid, ew);
      if (ew) begin
        e = win_q.pop_front();
        chk("win_ker", bus.win_ker, e.k);
        chk("win_row", bus.win_row, e.r);
        chk("win_col", bus.win_col, e.c);
      end
      er = (res_q.size() != 0) && (res_q[0].cyc == cyc);
      chk("res_valid", bus.res_valid, er);
      if (er) begin
        e = res_q.pop_front();
        chk("res_ker", bus.res_ker, e.k);
        chk("res_row", bus.res_row, e.r);
        chk("res_col", bus.res_col, e.c);
      end
      ed = (done_q.size() != 0) && (done_q[0] == cyc);
      chk("done", bus.done, ed);
      if (ed) void'(done_q.pop_front());
    end
  end

  task automatic main_seq();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    scenario(145, 1);
    scenario(150, 2);
    scenario(220, 3);
    scenario(145, 4);
    scenario(200, 6);
    for (int i = 0; i < 8; i++) scenario(260, 7);
    scenario(200, 0);
    chk("win_leftover", win_q.size(), 0);
    chk("res_leftover", res_q.size(), 0);
    chk("done_leftover", done_q.size(), 0);
  endtask

  // Default geometry: every window in order, then count and final tag
  task automatic big_seq();
    int n = 0;
    int lk = -1, lr = -1, lc = -1;
    bit seen_done = 1'b0;
    big_rstn = 1'b0;
    big_bus.start = 1'b0; big_bus.abort = 1'b0; big_bus.ds_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    big_rstn = 1'b1;
    big_bus.start = 1'b1;
    @(posedge clk);
    #1;
    big_bus.start = 1'b0;
    for (int i = 0; i < 12000 && !seen_done; i++) begin
      @(negedge clk);
      if (big_bus.win_valid) begin
        chk("big_tag", {big_bus.win_ker, big_bus.win_row, big_bus.win_col},
            {3'(n / (B_OUT * B_OUT)), 5'((n / B_OUT) % B_OUT), 5'(n % B_OUT)});
        lk = int'(big_bus.win_ker); lr = int'(big_bus.win_row); lc = int'(big_bus.win_col);
        n++;
      end
      if (big_bus.done) seen_done = 1'b1;
    end
    chk("big_done_seen", seen_done, 1);
    chk("big_count", n, B_TOTAL);
    chk("big_last_ker", lk, 5);
    chk("big_last_row", lr, 27);
    chk("big_last_col", lc, 27);
  endtask

  initial begin
    rstn = 1'b0;
    big_rstn = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.ds_ready = 1'b1;
    big_bus.start = 1'b0; big_bus.abort = 1'b0; big_bus.ds_ready = 1'b1;
    fork
      main_seq();
      big_seq();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
